// File: rtl/shift_right_iterative.sv
// Multi-cycle SRL/SRA: one binary shift stage per clock, LSB stage first, valid/ready on both sides.
// Optional SHIFT_RIGHT_EARLY_EXIT_EN: finish as soon as no higher shift-amount bits remain.
module shift_right_iterative #(
    parameter int N = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] in,
    input  logic [L-1:0] shamt,
    input  logic         arith,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] out
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [L-1:0] K_LAST = L'(L - 1);

    state_t       state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic [L-1:0] amt_q, amt_d;
    logic [L-1:0] k_q, k_d;
    logic         arith_q, arith_d;

    logic         fill;
    logic [N-1:0] stage_opt [L];
    logic [N-1:0] stage_out;
    logic         last_stage;
    logic         accept;

    assign fill   = arith_q & data_q[N-1];
    assign accept = i_valid && i_ready;

    // Each candidate is a fixed-distance shift by 2^j; the counter picks one per cycle.
    for (genvar j = 0; j < L; j++) begin : g_stage
        localparam int S = 2 ** j;
        assign stage_opt[j] = {{S{fill}}, data_q[N-1:S]};
    end

    assign stage_out = amt_q[k_q] ? stage_opt[k_q] : data_q;

`ifdef SHIFT_RIGHT_EARLY_EXIT_EN
    assign last_stage = (k_q == K_LAST) || (((amt_q >> k_q) >> 1) == '0);
`else
    assign last_stage = (k_q == K_LAST);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            arith_q <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            arith_q <= arith_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_stage) state_d = DONE;
            DONE:    if (o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        amt_d   = amt_q;
        arith_d = arith_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in;
                    amt_d   = shamt;
                    arith_d = arith;
                    k_d     = '0;
                end
            end
            SHIFT: begin
                data_d = stage_out;
                if (!last_stage) k_d = k_q + L'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        i_ready = (state_q == IDLE) && rst;
        o_valid = (state_q == DONE);
        out     = data_q;
    end

endmodule

// File: tb/tb_shift_right_iterative.sv
// Self-checking bench for shift_right_iterative: directed vector table, handshake corner cases,
// and a random sweep against an arithmetic reference model.
module tb_shift_right_iterative;

    localparam int N = 32;
    localparam int L = 5;

    typedef struct {
        logic [N-1:0] vin;
        logic [L-1:0] sh;
        logic         ar;
        logic [N-1:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready = 1'b0;
    logic         arith = 1'b0;
    logic [N-1:0] in_v = '0;
    logic [L-1:0] shamt = '0;
    logic         i_ready;
    logic         o_valid;
    logic [N-1:0] out_v;

    int total = 0;
    int bad = 0;

    shift_right_iterative #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .in     (in_v),
        .shamt  (shamt),
        .arith  (arith),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .out    (out_v)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] refShift(input logic [N-1:0] v, input logic [L-1:0] s, input logic a);
        logic signed [N-1:0] sv;
        sv = v;
        if (a) return sv >>> s;
        return v >> s;
    endfunction

    function automatic int refLatency(input logic [L-1:0] s);
`ifdef SHIFT_RIGHT_EARLY_EXIT_EN
        int h;
        h = 1;
        for (int b = 0; b < L; b++) if (s[b]) h = b + 1;
        return h;
`else
        return L;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for i_ready, accepts one operand, scrambles inputs, then waits for o_valid.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [L-1:0] s, input logic a,
                                 output logic [N-1:0] res, output int lat);
        int waitCnt;
        waitCnt = 0;
        while (!i_ready && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkOutput("accept_ready", N'(i_ready), N'(1));
        in_v    = v;
        shamt   = s;
        arith   = a;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        in_v    = $urandom;
        shamt   = L'($urandom);
        arith   = ~a;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!o_valid && lat < 40);
        res = out_v;
    endtask

    task automatic handoff();
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        checkOutput("post_handoff_ovalid", N'(o_valid), N'(0));
        checkOutput("post_handoff_iready", N'(i_ready), N'(1));
    endtask

    task automatic runOp(input string name, input logic [N-1:0] v, input logic [L-1:0] s,
                         input logic a, input logic [N-1:0] exp);
        logic [N-1:0] res;
        int           lat;
        applyStimulus(v, s, a, res, lat);
        checkOutput({name, "_result"}, res, exp);
        checkOutput({name, "_latency"}, N'(lat), N'(refLatency(s)));
        handoff();
    endtask

    vec_t vecs[10];

    initial begin
        logic [N-1:0] res;
        logic [N-1:0] held;
        logic [N-1:0] rv;
        logic [L-1:0] rs;
        logic         ra;
        int           lat;

        vecs[0] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[2] = '{32'hF0F0_1234, 5'd4,  1'b1, 32'hFF0F_0123};
        vecs[3] = '{32'hF0F0_1234, 5'd4,  1'b0, 32'h0F0F_0123};
        vecs[4] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
        vecs[7] = '{32'h0000_0100, 5'd8,  1'b0, 32'h0000_0001};
        vecs[8] = '{32'h1234_5678, 5'd16, 1'b1, 32'h0000_1234};
        vecs[9] = '{32'h8000_0001, 5'd1,  1'b1, 32'hC000_0000};

        // Reset state while rst is held low, including across a clock edge.
        #12;
        checkOutput("reset_ovalid", N'(o_valid), N'(0));
        checkOutput("reset_iready", N'(i_ready), N'(0));
        checkOutput("reset_out", out_v, '0);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("release_iready", N'(i_ready), N'(1));

        for (int i = 0; i < 10; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].vin, vecs[i].sh, vecs[i].ar, vecs[i].exp);
        end

`ifdef SHIFT_RIGHT_EARLY_EXIT_EN
        applyStimulus(32'hA000_0000, 5'd1, 1'b0, res, lat);
        checkOutput("early_sh1_latency", N'(lat), N'(1));
        checkOutput("early_sh1_result", res, 32'h5000_0000);
        handoff();
        applyStimulus(32'hA000_0000, 5'd16, 1'b1, res, lat);
        checkOutput("early_sh16_latency", N'(lat), N'(5));
        checkOutput("early_sh16_result", res, 32'hFFFF_A000);
        handoff();
`endif

        // Backpressure: result must hold and new requests must be ignored.
        applyStimulus(32'hA5A5_0000, 5'd12, 1'b1, held, lat);
        checkOutput("bp_first", held, 32'hFFFA_5A50);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_v    = 32'h1111_1111;
                shamt   = 5'd3;
                i_valid = 1'b1;
            end
            tick();
            i_valid = 1'b0;
            checkOutput($sformatf("bp_out_c%0d", c), out_v, 32'hFFFA_5A50);
            checkOutput($sformatf("bp_iready_c%0d", c), N'(i_ready), N'(0));
            checkOutput($sformatf("bp_ovalid_c%0d", c), N'(o_valid), N'(1));
        end
        handoff();

        // Reset two cycles into SHIFT.
        while (!i_ready) tick();
        in_v    = 32'hFFFF_0000;
        shamt   = 5'd20;
        arith   = 1'b1;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_shift_ovalid", N'(o_valid), N'(0));
        checkOutput("rst_shift_iready", N'(i_ready), N'(0));
        checkOutput("rst_shift_out", out_v, '0);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rst_shift_release_iready", N'(i_ready), N'(1));

        // Reset while holding a result: o_valid must drop without a clock edge.
        applyStimulus(32'h0F00_0000, 5'd4, 1'b0, res, lat);
        checkOutput("rst_done_pre_ovalid", N'(o_valid), N'(1));
        rst = 1'b0;
        #1;
        checkOutput("rst_done_ovalid", N'(o_valid), N'(0));
        checkOutput("rst_done_iready", N'(i_ready), N'(0));
        tick();
        rst = 1'b1;
        #1;
        runOp("after_reset", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001);

        for (int r = 0; r < 1000; r++) begin
            rv = $urandom;
            rs = L'($urandom_range(0, N - 1));
            ra = 1'($urandom_range(0, 1));
            applyStimulus(rv, rs, ra, res, lat);
            checkOutput($sformatf("rand%0d_result", r), res, refShift(rv, rs, ra));
            checkOutput($sformatf("rand%0d_latency", r), N'(lat), N'(refLatency(rs)));
            for (int d = 0; d < int'($urandom_range(0, 2)); d++) tick();
            handoff();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
